// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for decode_stage.
// The slave side is the decode stage. The master side is whatever drives fetch
// and consumes the decoded bundle.
interface decode_stage_if;
    logic [31:0] ir;
    logic [31:0] pc1;
    logic        if_valid;
    logic        ex_stall;
    logic        flush;
    logic        stall_fetch;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] id_imm;
    logic [3:0]  id_alu_op;
    logic        id_alu_src_imm;
    logic        id_reg_we;
    logic        id_mem_re;
    logic        id_mem_we;
    logic [2:0]  id_funct3;
    logic        id_is_branch;
    logic        id_is_jal;
    logic        id_is_jalr;
    logic        id_is_lui;
    logic        id_is_auipc;
    logic        id_illegal;

    modport slave (
        input  ir, pc1, if_valid, ex_stall, flush,
        output stall_fetch, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm,
               id_alu_op, id_alu_src_imm, id_reg_we, id_mem_re, id_mem_we,
               id_funct3, id_is_branch, id_is_jal, id_is_jalr, id_is_lui,
               id_is_auipc, id_illegal
    );

    modport master (
        output ir, pc1, if_valid, ex_stall, flush,
        input  stall_fetch, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm,
               id_alu_op, id_alu_src_imm, id_reg_we, id_mem_re, id_mem_we,
               id_funct3, id_is_branch, id_is_jal, id_is_jalr, id_is_lui,
               id_is_auipc, id_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage. It decodes one instruction per cycle into a registered
// bundle and detects load-use hazards against the instruction currently held
// in decode.
module decode_stage (
    input  logic           clk,
    input  logic           reset,
    decode_stage_if.slave  bus
);
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        alu_src_imm;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic [2:0]  funct3;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        is_lui;
        logic        is_auipc;
        logic        illegal;
    } bundle_t;

    // funct3 -> ALU op. alt selects SUB for funct3 0 and SRA for funct3 5.
    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_sel = alt ? 4'd1 : 4'd0;
            3'd1:    alu_sel = 4'd2;
            3'd2:    alu_sel = 4'd3;
            3'd3:    alu_sel = 4'd4;
            3'd4:    alu_sel = 4'd5;
            3'd5:    alu_sel = alt ? 4'd7 : 4'd6;
            3'd6:    alu_sel = 4'd8;
            default: alu_sel = 4'd9;
        endcase
    endfunction

    bundle_t dec;
    bundle_t id_d, id_q;
    logic    load_use;
    logic    rs2_used;

    logic [6:0]  opcode;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = bus.ir[6:0];
    assign imm_i  = {{20{bus.ir[31]}}, bus.ir[31:20]};
    assign imm_s  = {{20{bus.ir[31]}}, bus.ir[31:25], bus.ir[11:7]};
    assign imm_b  = {{19{bus.ir[31]}}, bus.ir[31], bus.ir[7], bus.ir[30:25], bus.ir[11:8], 1'b0};
    assign imm_u  = {bus.ir[31:12], 12'b0};
    assign imm_j  = {{11{bus.ir[31]}}, bus.ir[31], bus.ir[19:12], bus.ir[20], bus.ir[30:21], 1'b0};

    // Combinational decode of the fetched word into a bundle.
    always_comb begin
        dec        = '0;
        rs2_used   = 1'b0;
        dec.valid  = bus.if_valid;
        dec.pc     = bus.pc1;
        dec.funct3 = bus.ir[14:12];
        dec.rs1    = bus.ir[19:15];
        dec.rd     = bus.ir[11:7];
        case (opcode)
            OPC_LUI: begin
                dec.is_lui = 1'b1; dec.imm = imm_u; dec.alu_op = ALU_PASSB;
                dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1; dec.rs1 = 5'd0;
            end
            OPC_AUIPC: begin
                dec.is_auipc = 1'b1; dec.imm = imm_u; dec.alu_op = ALU_ADD;
                dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1;
            end
            OPC_JAL: begin
                dec.is_jal = 1'b1; dec.imm = imm_j; dec.reg_we = 1'b1; dec.rs1 = 5'd0;
            end
            OPC_JALR: begin
                dec.is_jalr = 1'b1; dec.imm = imm_i; dec.alu_op = ALU_ADD;
                dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1;
            end
            OPC_BRANCH: begin
                dec.is_branch = 1'b1; dec.imm = imm_b; dec.alu_op = ALU_SUB;
                rs2_used = 1'b1; dec.rd = 5'd0;
            end
            OPC_LOAD: begin
                dec.mem_re = 1'b1; dec.imm = imm_i; dec.alu_op = ALU_ADD;
                dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1;
            end
            OPC_STORE: begin
                dec.mem_we = 1'b1; dec.imm = imm_s; dec.alu_op = ALU_ADD;
                dec.alu_src_imm = 1'b1; rs2_used = 1'b1; dec.rd = 5'd0;
            end
            OPC_OPIMM: begin
                dec.imm = imm_i; dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1;
                // ir[30] is part of the immediate except for the right shifts
                dec.alu_op = alu_sel(bus.ir[14:12], (bus.ir[14:12] == 3'd5) && bus.ir[30]);
            end
            OPC_OP: begin
                dec.alu_op = alu_sel(bus.ir[14:12], bus.ir[30]);
                dec.reg_we = 1'b1; rs2_used = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1; dec.rd = 5'd0;
            end
        endcase
        if (rs2_used) dec.rs2 = bus.ir[24:20];
        if (dec.rd == 5'd0) dec.reg_we = 1'b0;
    end

    // A load in decode whose destination feeds the incoming instruction.
    assign load_use = id_q.valid && id_q.mem_re && (id_q.rd != 5'd0) && bus.if_valid &&
                      ((dec.rs1 == id_q.rd) || (rs2_used && (dec.rs2 == id_q.rd)));

    assign bus.stall_fetch = reset && !bus.flush && (bus.ex_stall || load_use);

    // Next-state selection: flush beats a downstream stall, which beats a load-use bubble.
    always_comb begin
        id_d = dec;
        if (bus.flush) begin
            id_d       = id_q;
            id_d.valid = 1'b0;
        end else if (bus.ex_stall) begin
            id_d = id_q;
        end else if (load_use) begin
            id_d       = id_q;
            id_d.valid = 1'b0;
        end
    end

    // Registered decode bundle; synchronous reset clears every field.
    always_ff @(posedge clk) begin
        if (!reset) id_q <= '0;
        else        id_q <= id_d;
    end

    assign bus.id_valid       = id_q.valid;
    assign bus.id_pc          = id_q.pc;
    assign bus.id_rs1         = id_q.rs1;
    assign bus.id_rs2         = id_q.rs2;
    assign bus.id_rd          = id_q.rd;
    assign bus.id_imm         = id_q.imm;
    assign bus.id_alu_op      = id_q.alu_op;
    assign bus.id_alu_src_imm = id_q.alu_src_imm;
    assign bus.id_reg_we      = id_q.reg_we;
    assign bus.id_mem_re      = id_q.mem_re;
    assign bus.id_mem_we      = id_q.mem_we;
    assign bus.id_funct3      = id_q.funct3;
    assign bus.id_is_branch   = id_q.is_branch;
    assign bus.id_is_jal      = id_q.is_jal;
    assign bus.id_is_jalr     = id_q.is_jalr;
    assign bus.id_is_lui      = id_q.is_lui;
    assign bus.id_is_auipc    = id_q.is_auipc;
    assign bus.id_illegal     = id_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with hand-computed expected values.
module tb_decode_stage;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    decode_stage_if bus();

    decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc);
        bus.ir = ir; bus.pc1 = pc; bus.if_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.ex_stall = 1'b1; bus.flush = 1'b0;
        drive(32'h00500093, 32'h0000_0FFC);
        #1;
        checks++; if (bus.stall_fetch !== 1'b0) begin failures++; $display("FAIL rst_stall_fetch got=%b exp=0", bus.stall_fetch); end
        tick(); tick();
        checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.id_valid); end
        checks++; if ({bus.id_pc, bus.id_imm, bus.id_rd, bus.id_rs1} !== 74'd0) begin failures++; $display("FAIL rst_fields pc=%h imm=%h rd=%0d rs1=%0d exp=0", bus.id_pc, bus.id_imm, bus.id_rd, bus.id_rs1); end
        checks++; if ({bus.id_reg_we, bus.id_alu_src_imm, bus.id_illegal, bus.id_alu_op} !== 7'd0) begin failures++; $display("FAIL rst_flags we=%b src=%b ill=%b alu=%0d exp=0", bus.id_reg_we, bus.id_alu_src_imm, bus.id_illegal, bus.id_alu_op); end
        reset = 1'b1; bus.ex_stall = 1'b0;
    endtask

    task automatic test_addi();
        drive(32'h00500093, 32'h0000_1000);
        tick();
        checks++; if ({bus.id_valid, bus.id_rd, bus.id_rs1} !== {1'b1, 5'd1, 5'd0}) begin failures++; $display("FAIL addi_regs v=%b rd=%0d rs1=%0d exp v=1 rd=1 rs1=0", bus.id_valid, bus.id_rd, bus.id_rs1); end
        checks++; if (bus.id_imm !== 32'h0000_0005) begin failures++; $display("FAIL addi_imm got=%h exp=00000005", bus.id_imm); end
        checks++; if ({bus.id_alu_op, bus.id_alu_src_imm, bus.id_reg_we} !== {4'd0, 1'b1, 1'b1}) begin failures++; $display("FAIL addi_ctl alu=%0d src=%b we=%b exp 0/1/1", bus.id_alu_op, bus.id_alu_src_imm, bus.id_reg_we); end
        checks++; if (bus.id_pc !== 32'h0000_1000) begin failures++; $display("FAIL addi_pc got=%h exp=00001000", bus.id_pc); end
    endtask

    task automatic test_load_use();
        drive(32'h0000A103, 32'h0000_1004);
        tick();
        checks++; if ({bus.id_mem_re, bus.id_rd, bus.id_reg_we} !== {1'b1, 5'd2, 1'b1}) begin failures++; $display("FAIL lw_decode re=%b rd=%0d we=%b exp 1/2/1", bus.id_mem_re, bus.id_rd, bus.id_reg_we); end
        drive(32'h001101B3, 32'h0000_1008);
        #1;
        checks++; if (bus.stall_fetch !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", bus.stall_fetch); end
        tick();
        checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%b exp=0", bus.id_valid); end
        checks++; if (bus.stall_fetch !== 1'b0) begin failures++; $display("FAIL lu_stall_release got=%b exp=0", bus.stall_fetch); end
        tick();
        checks++; if ({bus.id_valid, bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_alu_op} !== {1'b1, 5'd2, 5'd1, 5'd3, 4'd0}) begin failures++; $display("FAIL lu_add v=%b rs1=%0d rs2=%0d rd=%0d alu=%0d exp 1/2/1/3/0", bus.id_valid, bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_alu_op); end
        checks++; if (bus.id_pc !== 32'h0000_1008) begin failures++; $display("FAIL lu_add_pc got=%h exp=00001008", bus.id_pc); end
    endtask

    task automatic test_formats();
        drive(32'hFE000EE3, 32'h0000_2000);
        tick();
        checks++; if (bus.id_imm !== 32'hFFFF_FFFC) begin failures++; $display("FAIL beq_imm got=%h exp=fffffffc", bus.id_imm); end
        checks++; if ({bus.id_is_branch, bus.id_alu_op, bus.id_reg_we} !== {1'b1, 4'd1, 1'b0}) begin failures++; $display("FAIL beq_ctl br=%b alu=%0d we=%b exp 1/1/0", bus.id_is_branch, bus.id_alu_op, bus.id_reg_we); end
        drive(32'h123452B7, 32'h0000_2004);
        tick();
        checks++; if (bus.id_imm !== 32'h1234_5000) begin failures++; $display("FAIL lui_imm got=%h exp=12345000", bus.id_imm); end
        checks++; if ({bus.id_is_lui, bus.id_alu_op, bus.id_reg_we, bus.id_rd, bus.id_rs1} !== {1'b1, 4'd10, 1'b1, 5'd5, 5'd0}) begin failures++; $display("FAIL lui_ctl lui=%b alu=%0d we=%b rd=%0d rs1=%0d exp 1/10/1/5/0", bus.id_is_lui, bus.id_alu_op, bus.id_reg_we, bus.id_rd, bus.id_rs1); end
        drive(32'h40628233, 32'h0000_2008);  // sub x4,x5,x6
        tick();
        checks++; if ({bus.id_alu_op, bus.id_alu_src_imm, bus.id_rs1, bus.id_rs2, bus.id_imm} !== {4'd1, 1'b0, 5'd5, 5'd6, 32'd0}) begin failures++; $display("FAIL sub alu=%0d src=%b rs1=%0d rs2=%0d imm=%h exp 1/0/5/6/0", bus.id_alu_op, bus.id_alu_src_imm, bus.id_rs1, bus.id_rs2, bus.id_imm); end
        drive(32'h40345393, 32'h0000_200C);  // srai x7,x8,3
        tick();
        checks++; if ({bus.id_alu_op, bus.id_rd, bus.id_rs2} !== {4'd7, 5'd7, 5'd0}) begin failures++; $display("FAIL srai alu=%0d rd=%0d rs2=%0d exp 7/7/0", bus.id_alu_op, bus.id_rd, bus.id_rs2); end
        drive(32'h00312423, 32'h0000_2010);  // sw x3,8(x2)
        tick();
        checks++; if ({bus.id_mem_we, bus.id_reg_we, bus.id_rs1, bus.id_rs2, bus.id_imm, bus.id_funct3} !== {1'b1, 1'b0, 5'd2, 5'd3, 32'd8, 3'd2}) begin failures++; $display("FAIL sw we=%b rwe=%b rs1=%0d rs2=%0d imm=%h f3=%0d exp 1/0/2/3/8/2", bus.id_mem_we, bus.id_reg_we, bus.id_rs1, bus.id_rs2, bus.id_imm, bus.id_funct3); end
        drive(32'h010000EF, 32'h0000_2014);  // jal x1,16
        tick();
        checks++; if ({bus.id_is_jal, bus.id_reg_we, bus.id_rd, bus.id_rs1, bus.id_imm} !== {1'b1, 1'b1, 5'd1, 5'd0, 32'd16}) begin failures++; $display("FAIL jal jal=%b we=%b rd=%0d rs1=%0d imm=%h exp 1/1/1/0/10", bus.id_is_jal, bus.id_reg_we, bus.id_rd, bus.id_rs1, bus.id_imm); end
    endtask

    task automatic test_ex_stall();
        drive(32'h00500093, 32'h0000_3000);
        tick();
        bus.ex_stall = 1'b1;
        drive(32'h123452B7, 32'h0000_3004);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.stall_fetch !== 1'b1) begin failures++; $display("FAIL exs_stall_%0d got=%b exp=1", i, bus.stall_fetch); end
            tick();
            checks++; if ({bus.id_valid, bus.id_rd, bus.id_imm, bus.id_pc} !== {1'b1, 5'd1, 32'd5, 32'h0000_3000}) begin failures++; $display("FAIL exs_hold_%0d v=%b rd=%0d imm=%h pc=%h exp 1/1/5/3000", i, bus.id_valid, bus.id_rd, bus.id_imm, bus.id_pc); end
        end
        bus.ex_stall = 1'b0;
        tick();
        checks++; if ({bus.id_rd, bus.id_pc} !== {5'd5, 32'h0000_3004}) begin failures++; $display("FAIL exs_release rd=%0d pc=%h exp 5/3004", bus.id_rd, bus.id_pc); end
    endtask

    task automatic test_flush_load_use();
        drive(32'h0000A103, 32'h0000_4000);
        tick();
        drive(32'h001101B3, 32'h0000_4004);
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.stall_fetch !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", bus.stall_fetch); end
        tick();
        checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus.id_valid); end
        bus.flush = 1'b0;
        tick();
        checks++; if ({bus.id_valid, bus.id_rd} !== {1'b1, 5'd3}) begin failures++; $display("FAIL flush_next v=%b rd=%0d exp 1/3", bus.id_valid, bus.id_rd); end
    endtask

    task automatic test_illegal();
        drive(32'hFFFF_FFFF, 32'h0000_5000);
        tick();
        checks++; if ({bus.id_illegal, bus.id_valid} !== 2'b11) begin failures++; $display("FAIL ill_flag ill=%b v=%b exp 1/1", bus.id_illegal, bus.id_valid); end
        checks++; if ({bus.id_reg_we, bus.id_mem_re, bus.id_mem_we, bus.id_is_branch, bus.id_is_jal, bus.id_is_jalr, bus.id_is_lui, bus.id_is_auipc} !== 8'd0) begin failures++; $display("FAIL ill_enables got=%b%b%b%b%b%b%b%b exp=00000000", bus.id_reg_we, bus.id_mem_re, bus.id_mem_we, bus.id_is_branch, bus.id_is_jal, bus.id_is_jalr, bus.id_is_lui, bus.id_is_auipc); end
        drive(32'h00100013, 32'h0000_5004);
        tick();
        checks++; if ({bus.id_valid, bus.id_reg_we, bus.id_illegal, bus.id_imm} !== {1'b1, 1'b0, 1'b0, 32'd1}) begin failures++; $display("FAIL addi_x0 v=%b we=%b ill=%b imm=%h exp 1/0/0/1", bus.id_valid, bus.id_reg_we, bus.id_illegal, bus.id_imm); end
        bus.if_valid = 1'b0;
        tick();
        checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL if_invalid got=%b exp=0", bus.id_valid); end
    endtask

    task automatic test_reset_mid_stall();
        drive(32'h00500093, 32'h0000_6000);
        tick();
        bus.ex_stall = 1'b1;
        tick();
        checks++; if ({bus.id_valid, bus.id_rd} !== {1'b1, 5'd1}) begin failures++; $display("FAIL rms_hold v=%b rd=%0d exp 1/1", bus.id_valid, bus.id_rd); end
        reset = 1'b0;
        #1;
        checks++; if (bus.stall_fetch !== 1'b0) begin failures++; $display("FAIL rms_stall got=%b exp=0", bus.stall_fetch); end
        tick();
        checks++; if ({bus.id_valid, bus.id_rd, bus.id_imm, bus.id_pc, bus.id_reg_we} !== 71'd0) begin failures++; $display("FAIL rms_clear v=%b rd=%0d imm=%h pc=%h we=%b exp 0", bus.id_valid, bus.id_rd, bus.id_imm, bus.id_pc, bus.id_reg_we); end
        reset = 1'b1; bus.ex_stall = 1'b0;
        drive(32'h123452B7, 32'h0000_6004);
        tick();
        checks++; if ({bus.id_valid, bus.id_rd, bus.id_pc} !== {1'b1, 5'd5, 32'h0000_6004}) begin failures++; $display("FAIL rms_capture v=%b rd=%0d pc=%h exp 1/5/6004", bus.id_valid, bus.id_rd, bus.id_pc); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0;
        bus.ir = '0; bus.pc1 = '0; bus.if_valid = 1'b0; bus.ex_stall = 1'b0; bus.flush = 1'b0;
        test_reset();
        test_addi();
        test_load_use();
        test_formats();
        test_ex_stall();
        test_flush_load_use();
        test_illegal();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
